// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the conv/ReLU/max-pool engine blocks.
package cnn_pkg;

  localparam int unsigned DATA_W   = 20;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned L1_ELEMS = 1024;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as the output buffer of the layer-1 drain stage.
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 20,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when the same cycle frees a slot.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/l1_stream_out.sv
// Drains the pooled layer-1 map from layer memory and streams it over valid/ready.
// Optional running checksum on o_csum when CHECKSUM_EN is defined; tied to zero otherwise.
module l1_stream_out #(
  parameter int unsigned DATA_W     = cnn_pkg::DATA_W,
  parameter int unsigned ADDR_W     = cnn_pkg::ADDR_W,
  parameter int unsigned N_ELEM     = cnn_pkg::L1_ELEMS,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [2:0]  CSEL_SRC   = cnn_pkg::CSEL_L1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [2:0]        csel,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [DATA_W-1:0] o_csum
);

  import cnn_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_ELEM + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;
  logic               issue;
  logic               accept;
  logic               last_accept;
  logic [OCC_W-1:0]   occ;
  logic [DATA_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (cdata_rd),
    .pop       (accept),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign accept      = ~fifo_empty & o_ready;
  assign last_accept = accept & (wr_idx_q == IDX_W'(N_ELEM - 1));
  // Crediting this cycle's pop lets a 2-entry buffer sustain one word per cycle.
  assign occ = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(accept);

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    if (accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          rd_idx_d = '0;
          wr_idx_d = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (occ < OCC_W'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == IDX_W'(N_ELEM - 1)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          issue = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (last_accept) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + fifo_head;
    end else begin
      csum_d = csum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign o_csum = csum_q;
`else
  assign o_csum = '0;
`endif

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign crd      = issue;
  assign csel     = issue ? CSEL_SRC : CSEL_NONE;
  assign caddr_rd = issue ? ADDR_W'(rd_idx_q) : '0;
  assign o_valid  = ~fifo_empty;
  // Idle data lines read as zero so stale buffer contents never leak out.
  assign o_data   = fifo_empty ? '0 : fifo_head;
  assign o_last   = ~fifo_empty & (wr_idx_q == IDX_W'(N_ELEM - 1));

endmodule

// File: tb/tb_l1_stream_out.sv
// Directed bench for l1_stream_out: memory model, stream monitor and per-drain checks.
module tb_l1_stream_out;

  localparam int DW = 20;
  localparam int AW = 12;
  localparam int N  = 1024;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [DW-1:0] o_csum;

  l1_stream_out dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .csel     (csel),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_csum   (o_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem    [N];
  logic [DW-1:0] rx_mem [N];

  // Layer memory: one-cycle read latency.
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem[caddr_rd[9:0]];
  end

  int n_checks, n_fail, cyc;
  int issued, n_rx, data_err, last_err, csel_err, addr_err, occ_err, stab_err;
  int done_cnt, done_cyc;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    issued = 0; n_rx = 0; data_err = 0; last_err = 0; csel_err = 0;
    addr_err = 0; occ_err = 0; stab_err = 0; done_cnt = 0; done_cyc = -1;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  // One clock: drive o_ready after the edge, then sample the settled cycle.
  task automatic tick(input bit rdy);
    @(posedge clk);
    #1;
    start   = 1'b0;
    o_ready = rdy;
    #1;
    cyc++;
    if (o_last !== (o_valid && (n_rx == N - 1))) last_err++;
    if (prev_stall && (!o_valid || o_data !== prev_data)) stab_err++;
    prev_stall = o_valid && !o_ready;
    prev_data  = o_data;
    if (crd) begin
      if (csel !== 3'b011) csel_err++;
      if (caddr_rd !== AW'(issued)) addr_err++;
      issued++;
    end else if (csel !== 3'b000 || caddr_rd !== '0) begin
      csel_err++;
    end
    if (o_valid && o_ready) begin
      if (n_rx < N) begin
        rx_mem[n_rx] = o_data;
        if (o_data !== mem[n_rx]) data_err++;
      end
      n_rx++;
    end
    if (issued - n_rx > 2) occ_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  function automatic logic [DW-1:0] mem_sum();
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + mem[i];
`ifdef CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic drain(input string name, input int ready_pct, input int restart_at, input bit check_lat);
    int t0;
    int budget;
    clear_stats();
    start = 1'b1;
    t0 = cyc;
    tick(1'b1);
    check({name, "_busy"}, 32'(busy), 32'd1);
    budget = 0;
    while (done_cnt == 0 && budget < 10000) begin
      if (restart_at > 0 && (cyc - t0) == restart_at) start = 1'b1;
      tick($urandom_range(99, 0) < ready_pct);
      budget++;
    end
    check({name, "_timeout"}, 32'(done_cnt == 0), 32'd0);
    if (check_lat) check({name, "_latency"}, 32'(done_cyc - t0), 32'd1027);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    repeat (3) tick(1'b1);
    check({name, "_words"}, 32'(n_rx), 32'(N));
    check({name, "_reads"}, 32'(issued), 32'(N));
    check({name, "_data_err"}, 32'(data_err), 32'd0);
    check({name, "_last_err"}, 32'(last_err), 32'd0);
    check({name, "_csel_err"}, 32'(csel_err), 32'd0);
    check({name, "_addr_err"}, 32'(addr_err), 32'd0);
    check({name, "_occ_err"}, 32'(occ_err), 32'd0);
    check({name, "_stab_err"}, 32'(stab_err), 32'd0);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_csum"}, 32'(o_csum), 32'(mem_sum()));
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_ctl"}, 32'({busy, done, crd, o_valid, o_last}), 32'd0);
    check({name, "_csel_addr"}, 32'({csel, caddr_rd}), 32'd0);
    check({name, "_data"}, 32'(o_data), 32'd0);
    check({name, "_csum"}, 32'(o_csum), 32'd0);
  endtask

  initial begin
    int budget;
    logic [DW-1:0] csum_exp;
    reset = 1'b0; start = 1'b0; o_ready = 1'b0;
    cyc = 0; n_checks = 0; n_fail = 0;
    clear_stats();
    for (int i = 0; i < N; i++) mem[i] = DW'(i);

    tick(1'b0);
    tick(1'b0);
    check_idle_zero("rst");
    reset = 1'b1;
    tick(1'b0);

    // Test 1 / 6: full-rate drain of an index ramp.
    drain("t1", 100, 0, 1'b1);
`ifdef CHECKSUM_EN
    csum_exp = 20'h7FE00;
`else
    csum_exp = 20'h00000;
`endif
    check("t6_csum_ramp", 32'(o_csum), 32'(csum_exp));

    // Test 2: sink ready roughly 30% of cycles.
    drain("t2", 30, 0, 1'b0);

    // Test 3: extreme codes pass through bit-exact.
    mem[5] = 20'hFFFFF;
    mem[6] = 20'h80000;
    drain("t3", 100, 0, 1'b1);
    check("t3_word5", 32'(rx_mem[5]), 32'h000FFFFF);
    check("t3_word6", 32'(rx_mem[6]), 32'h00080000);
    mem[5] = DW'(5);
    mem[6] = DW'(6);

    // Test 4: second start mid-drain is ignored.
    drain("t4", 100, 100, 1'b1);

    // Test 5: reset mid-drain aborts silently, next drain restarts at 0.
    clear_stats();
    start = 1'b1;
    budget = 0;
    while (n_rx < 500 && budget < 2000) begin
      tick(1'b1);
      budget++;
    end
    check("t5_reach500", 32'(n_rx >= 500), 32'd1);
    reset = 1'b0;
    tick(1'b1);
    check_idle_zero("t5_rst1");
    tick(1'b1);
    check_idle_zero("t5_rst2");
    reset = 1'b1;
    repeat (10) tick(1'b1);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_idle", 32'({busy, o_valid}), 32'd0);
    drain("t5_new", 100, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
